// File: rtl/mem_interface.sv
// mem_interface: sequences one load/store at a time between the datapath and bram port A, with LED/switch MMIO
// Ports: clk/reset (async, active-low); req/we/addr/wdata request in; rdata/busy/done/addr_err status out;
//        bram_addr/bram_din/bram_we/bram_q to bram port A; sw_in switches in; led_out LED register out.
module mem_interface #(
   parameter int               WIDTH     = 16,
   parameter int               ADDR_BITS = 10,
   parameter logic [WIDTH-1:0] LED_ADDR  = 16'hFFFF,
   parameter logic [WIDTH-1:0] SW_ADDR   = 16'hFFFE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic                 we,
   input  logic [WIDTH-1:0]     addr,
   input  logic [WIDTH-1:0]     wdata,
   output logic [WIDTH-1:0]     rdata,
   output logic                 busy,
   output logic                 done,
   output logic                 addr_err,
   output logic [ADDR_BITS-1:0] bram_addr,
   output logic [WIDTH-1:0]     bram_din,
   output logic                 bram_we,
   input  logic [WIDTH-1:0]     bram_q,
   input  logic [9:0]           sw_in,
   output logic [WIDTH-1:0]     led_out
);
   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] addr_q, wdata_q;
   logic we_q;
   logic [9:0] sw_s1, sw_s2;
   logic hit_bram, hit_led, hit_sw;
   // upper address bits must be zero for bram space, so 0x0400 and above never alias
   assign hit_bram  = addr_q[WIDTH-1:ADDR_BITS] == '0;
   assign hit_led   = addr_q == LED_ADDR;
   assign hit_sw    = addr_q == SW_ADDR;
   assign busy      = state != IDLE;
   assign done      = state == DONE;
   // combinational from state so reset drops the write enable immediately
   assign bram_we   = state == ACCESS && hit_bram && we_q;
   assign bram_addr = addr_q[ADDR_BITS-1:0];
   assign bram_din  = wdata_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE)    ? (req ? ACCESS : IDLE) :
                 (state == ACCESS)  ? ((hit_bram && !we_q) ? CAPTURE : DONE) :
                 (state == CAPTURE) ? DONE : IDLE;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         rdata    <= '0;
         led_out  <= '0;
         addr_err <= 1'b0;
         sw_s1    <= '0;
         sw_s2    <= '0;
      end else begin
         sw_s1 <= sw_in;
         sw_s2 <= sw_s1;
         if (state == IDLE && req) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
         end
         if (state == ACCESS) begin
            if (hit_led && we_q) led_out <= wdata_q;
            if (hit_led && !we_q) rdata <= led_out;
            if (hit_sw && !we_q) rdata <= {{(WIDTH-10){1'b0}}, sw_s2};
            if (!hit_bram && !hit_led && !hit_sw) addr_err <= 1'b1;
         end
         if (state == CAPTURE) rdata <= bram_q;
      end
endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: directed self-checking bench for mem_interface with a small bram model on port A
module tb_mem_interface;
   logic        clk = 0, reset = 0, req = 0, we = 0;
   logic [15:0] addr = 0, wdata = 0, rdata, bram_din, bram_q, led_out;
   logic        busy, done, addr_err, bram_we;
   logic [9:0]  bram_addr, sw_in = 0;
   logic [15:0] mem [0:1023];
   int          n_tests = 0, n_fail = 0, we_cnt = 0, done_cnt = 0, lat;
   logic [15:0] acc_addr, acc_din, rd_at_done, led_at_done;
   logic        acc_we;

   mem_interface dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .addr_err(addr_err),
      .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_q(bram_q),
      .sw_in(sw_in), .led_out(led_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      bram_q <= mem[bram_addr];
   end

   always @(negedge clk) begin
      if (bram_we) we_cnt++;
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // called #1 after an edge in IDLE; lat counts cycles from the accepting edge until done is seen
   task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, output int l);
      we = w; addr = a; wdata = d; req = 1;
      @(posedge clk); #1;
      req = 0;
      acc_addr = {6'b0, bram_addr}; acc_din = bram_din; acc_we = bram_we;
      l = 1;
      while (!done && l < 8) begin
         @(posedge clk); #1;
         l++;
      end
      rd_at_done = rdata; led_at_done = led_out;
      @(posedge clk); #1;
   endtask

   initial begin
      int w0, d0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'hDEAD;
      req = 1; we = 1; addr = 16'h0002; wdata = 16'h1234;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_outs", {rdata, led_out, bram_din}, 0);
      check("rst_flags", {bram_addr, bram_we, done, addr_err}, 0);
      check("rst_we_cnt", we_cnt, 0);
      req = 0;
      @(negedge clk); reset = 1;
      @(posedge clk); #1;
      check("rst_idle", busy, 0);

      w0 = we_cnt;
      issue(1, 16'h0002, 16'h000F, lat);
      check("st_lat", lat, 2);
      check("st_acc_we", acc_we, 1);
      check("st_acc_addr", acc_addr, 16'h0002);
      check("st_acc_din", acc_din, 16'h000F);
      check("st_we_once", we_cnt - w0, 1);
      issue(0, 16'h0002, 16'h0000, lat);
      check("ld_lat", lat, 3);
      check("ld_rdata", rd_at_done, 16'h000F);

      w0 = we_cnt;
      req = 1; we = 1; addr = 16'h0000; wdata = 16'h3000;
      @(posedge clk); #1;
      check("b2b_we1", {bram_we, bram_addr}, {1'b1, 10'h000});
      @(posedge clk); #1;
      check("b2b_done1", done, 1);
      addr = 16'h03FF; wdata = 16'h0C00;
      @(posedge clk); #1;
      check("b2b_idle", busy, 0);
      @(posedge clk); #1;
      check("b2b_we2", {bram_we, bram_addr, bram_din}, {1'b1, 10'h3FF, 16'h0C00});
      req = 0;
      @(posedge clk); #1;
      check("b2b_done2", done, 1);
      @(posedge clk); #1;
      check("b2b_we_cnt", we_cnt - w0, 2);
      issue(0, 16'h0000, 0, lat);
      check("b2b_ld0", rd_at_done, 16'h3000);
      issue(0, 16'h03FF, 0, lat);
      check("b2b_ld3ff", rd_at_done, 16'h0C00);

      w0 = we_cnt;
      issue(1, 16'hFFFF, 16'hA5A5, lat);
      check("led_st_lat", lat, 2);
      check("led_at_done", led_at_done, 16'hA5A5);
      check("led_no_bram_we", we_cnt - w0, 0);
      check("st_keeps_rdata", rdata, 16'h0C00);
      issue(0, 16'hFFFF, 0, lat);
      check("led_ld", {lat[7:0], rd_at_done}, {8'd2, 16'hA5A5});
      sw_in = 10'h155;
      repeat (3) @(posedge clk);
      #1;
      issue(0, 16'hFFFE, 0, lat);
      check("sw_ld", {lat[7:0], rd_at_done}, {8'd2, 16'h0155});
      issue(1, 16'hFFFE, 16'h7777, lat);
      check("sw_st_lat", lat, 2);
      check("sw_st_nochg", {rdata, led_out, 15'b0, addr_err}, {16'h0155, 16'hA5A5, 16'h0000});
      check("sw_st_we", we_cnt - w0, 0);

      issue(0, 16'h0400, 0, lat);
      check("err_lat", lat, 2);
      check("err_flag", addr_err, 1);
      check("err_rdata", rd_at_done, 16'h0155);
      issue(0, 16'h0002, 0, lat);
      check("err_sticky", {addr_err, rdata}, {1'b1, 16'h000F});

      d0 = done_cnt;
      req = 1; we = 0; addr = 16'h0003;
      @(posedge clk); #1;
      req = 0;
      @(posedge clk); #1;
      req = 1; we = 1; addr = 16'hFFFF; wdata = 16'hFFFF;
      @(posedge clk); #1;
      req = 0;
      check("stall_done", done, 1);
      repeat (4) @(posedge clk);
      #1;
      check("stall_one_done", done_cnt - d0, 1);
      check("stall_led", led_out, 16'hA5A5);
      check("stall_idle", busy, 0);

      w0 = we_cnt;
      req = 1; we = 1; addr = 16'h0005; wdata = 16'hBEEF;
      @(posedge clk); #1;
      req = 0;
      check("mid_we_pre", bram_we, 1);
      #1 reset = 0;
      #1;
      check("mid_we_drop", bram_we, 0);
      check("mid_state", {busy, done, addr_err}, 0);
      @(posedge clk); #1;
      check("mid_no_write", {we_cnt - w0, mem[5]}, {32'd0, 16'hDEAD});
      @(negedge clk); reset = 1;
      @(posedge clk); #1;
      check("mid_idle", {busy, rdata, led_out}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- Load/store interface between the datapath's memory port (mem_addr, Rsrc, mem_out) and port A of the 16x1024 dual-port bram.
- Accepts one request at a time through a req/busy/done handshake and sequences the bram's one-cycle registered read latency.
- Decodes a 16-bit address into bram space or two memory-mapped I/O registers: LED output and switch input.
- Lets the controller FSM stall on busy instead of hand-timing bram write enables.

Parameters:
- WIDTH, 16, data width of datapath words and bram words.
- ADDR_BITS, 10, bram address width; bram space is 0 .. 2^ADDR_BITS-1.
- LED_ADDR, 16'hFFFF, address of the LED output register (read/write).
- SW_ADDR, 16'hFFFE, address of the switch input (read-only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req  in  1  request strobe from the controller; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  WIDTH  byte-free word address (datapath mem_addr).
- wdata  in  WIDTH  store data (datapath Rsrc).
- rdata  out  WIDTH  load result (datapath mem_out).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse marking request completion.
- addr_err  out  1  sticky flag: a request hit an unmapped address.
- bram_addr  out  ADDR_BITS  to bram addr_a.
- bram_din  out  WIDTH  to bram data_a.
- bram_we  out  1  to bram we_a.
- bram_q  in  WIDTH  from bram q_a; registered, valid one cycle after the address edge.
- sw_in  in  10  board switches, unsynchronised.
- led_out  out  WIDTH  LED register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - rdata, led_out, bram_addr, bram_din = 0.
  - bram_we, done, busy, addr_err = 0.
  - Switch synchroniser flops cleared.
  - Reset in mid-operation abandons the request; no bram write occurs after reset is asserted.
- Address decode on the latched address:
  - BRAM when addr < 2^ADDR_BITS.
  - LED when addr == LED_ADDR.
  - SW when addr == SW_ADDR.
  - Otherwise ERR.
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE:
  - busy=0.
  - If req=1: latch addr, we, wdata; go to ACCESS.
  - If req=0: stay in IDLE.
- ACCESS:
  - bram_addr = latched addr[ADDR_BITS-1:0], bram_din = latched wdata.
  - bram_we=1 only for a BRAM store, and for exactly this one cycle.
  - Next state:
    - BRAM load goes to CAPTURE.
    - LED store: led_out <= wdata at the edge leaving ACCESS; go to DONE.
    - LED load: rdata <= led_out; go to DONE.
    - SW load: rdata <= zero-extended synchronised switches; go to DONE.
    - SW store: ignored; go to DONE.
    - ERR: addr_err <= 1; rdata unchanged; go to DONE.
    - BRAM store: go to DONE.
- CAPTURE: rdata <= bram_q; go to DONE.
- DONE: done=1, busy=1; go to IDLE unconditionally.
- Latency, with req sampled at edge k:
  - BRAM load: done high in cycle k+3; rdata valid from k+3.
  - All other requests: done in cycle k+2.
- Handshake:
  - req while busy=1 is ignored, never queued. The controller holds or re-issues req after done.
  - req high in the cycle IDLE is re-entered is accepted: back-to-back throughput is 1 request per 3 cycles (4 for BRAM loads).
- rdata holds its value until the next load completes; stores never modify rdata.
- addr_err clears only on reset.
- sw_in passes through a 2-flop synchroniser before use.
- bram port B is untouched by this block.
- Address wrap: the upper bits of BRAM addresses are always zero by decode. No aliasing; 0x0400 is ERR.

Test Plan:
- Reset: hold reset=0 with req=1 -> all outputs 0, busy=0, bram_we never asserted; release -> IDLE.
- BRAM store then load:
  - Store wdata=16'h000F to addr 0x0002 -> bram_we high exactly one cycle with bram_addr=10'h002, done at k+2.
  - Load from 0x0002 -> done at k+3, rdata=16'h000F.
- Back-to-back:
  - Stores 16'h3000 to 0x0000 and 16'h0C00 to 0x03FF, req held high -> second accepted on the IDLE cycle after done.
  - Loads return 16'h3000 and 16'h0C00.
- MMIO:
  - Store 16'hA5A5 to 0xFFFF -> led_out=16'hA5A5 at k+2; load 0xFFFF -> rdata=16'hA5A5.
  - sw_in=10'h155, load 0xFFFE -> rdata=16'h0155.
  - Store to 0xFFFE -> no change anywhere.
- Error and stall:
  - Load 0x0400 -> addr_err=1 and done at k+2; rdata keeps its prior value.
  - req pulsed during busy -> ignored; no extra done.
- Reset mid-op: assert reset during ACCESS of a BRAM store -> bram_we drops immediately, state IDLE, addr_err=0.
